// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   NUM_REQ : number of requesters sharing the 4:1 mux
//   SEL_W   : width of the mux select / requester index
//   state_t : arbiter FSM states
//   win_t   : result of a round-robin winner search
//   onehot  : index -> one-hot grant vector
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } win_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bus of the round-robin mux arbiter.
//   req  : request lines, req[i] <-> mux input i (a,b,c,d)
//   din  : data bits presented to the mux, din[i] <-> mux input i
//   gnt  : registered one-hot grant, zero when idle
//   sel  : registered mux select (index of granted requester)
//   busy : high while a grant is active
//   dout : registered mux output, lags sel by one cycle
// master = requester/environment side, slave = arbiter side.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               dout;

  modport master (
    output req, din,
    input  gnt, sel, busy, dout
  );

  modport slave (
    input  req, din,
    output gnt, sel, busy, dout
  );

endinterface

// File: rtl/mux_rr_arbiter_mux.sv
// Existing 4:1 single-bit multiplexer shared by the arbiter.
//   a, b, c, d : data inputs (select 0..3)
//   s          : 2-bit select
//   out        : selected data bit (combinational)
module mux_rr_arbiter_mux (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] s,
  output logic       out
);

  always_comb begin
    out = 1'b0;
    case (s)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of the shared 4:1 mux.
// Grants one requester at a time, drives the mux select from the grant,
// limits each grant to MAX_HOLD consecutive cycles and registers the
// selected data bit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester bus (slave side), see mux_rr_arbiter_if
// Parameters:
//   MAX_HOLD : max consecutive cycles per grant (1..15)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD-1
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);
  import mux_rr_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] gnt_r;
  logic [SEL_W-1:0]   sel_r;
  logic               busy_r;
  logic               dout_r;
  logic               mux_out;

  logic               release_now;
  logic [SEL_W-1:0]   next_ptr;
  win_t               idle_win;
  win_t               rel_win;

  // First set req bit at or after start, wrapping mod NUM_REQ.
  // Scanning offsets from the far end lets the nearest hit overwrite.
  function automatic win_t find_winner(input logic [NUM_REQ-1:0] r,
                                       input logic [SEL_W-1:0]   start);
    win_t             w;
    logic [SEL_W-1:0] idx;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (r[idx]) begin
        w.found = 1'b1;
        w.idx   = idx;
      end
    end
    return w;
  endfunction

  // Dropped request and hold expiry in the same cycle are a single release.
  // The released requester's bit is already low when it dropped, so the
  // plain req vector acts as the masked search input; when it is still high
  // (expiry) the wrap-around lets a sole requester win again.
  always_comb begin
    release_now = !bus.req[sel_r] || (hold_cnt == HOLD_LAST);
    next_ptr    = sel_r + SEL_W'(1);
    idle_win    = find_winner(bus.req, ptr);
    rel_win     = find_winner(bus.req, next_ptr);
  end

  mux_rr_arbiter_mux u_mux (
    .a   (bus.din[0]),
    .b   (bus.din[1]),
    .c   (bus.din[2]),
    .d   (bus.din[3]),
    .s   (sel_r),
    .out (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_r    <= '0;
      sel_r    <= '0;
      busy_r   <= 1'b0;
      dout_r   <= 1'b0;
    end else begin
      // output register: mux output sampled with the select of this cycle
      dout_r <= busy_r ? mux_out : 1'b0;

      case (state)
        ST_IDLE: begin
          if (idle_win.found) begin
            state    <= ST_GRANT;
            gnt_r    <= onehot(idle_win.idx);
            sel_r    <= idle_win.idx;
            busy_r   <= 1'b1;
            hold_cnt <= '0;
          end
        end

        ST_GRANT: begin
          if (!release_now) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end else begin
            ptr      <= next_ptr;
            hold_cnt <= '0;
            if (rel_win.found) begin
              gnt_r <= onehot(rel_win.idx);
              sel_r <= rel_win.idx;
            end else begin
              state  <= ST_IDLE;
              gnt_r  <= '0;
              busy_r <= 1'b0;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          gnt_r  <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.sel  = sel_r;
  assign bus.busy = busy_r;
  assign bus.dout = dout_r;

endmodule
